// File: rtl/case_1_mul_pipe_rs.sv
// Pipelined signed/unsigned multiplier with valid/ready flow control.
// The output stage applies round, shift and saturate, and counts clamped results.
module case_1_mul_pipe_rs #(
  parameter int ID          = 1,
  parameter int NUM_STAGE   = 3,
  parameter int din0_WIDTH  = 14,
  parameter int din1_WIDTH  = 12,
  parameter int dout_WIDTH  = 16,
  parameter int din0_SIGNED = 1,
  parameter int din1_SIGNED = 1,
  parameter int SHIFT       = 8,
  parameter int ROUND       = 1,
  parameter int SAT         = 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  sat_flag,
  input  logic                  cnt_clr,
  output logic [15:0]           sat_cnt
);

  localparam int P = din0_WIDTH + din1_WIDTH + 2;
  // Q leaves headroom for the rounding add and for the clamp limits.
  localparam int Q = ((P + 1) > (dout_WIDTH + 2)) ? (P + 1) : (dout_WIDTH + 2);
  localparam bit RES_SIGNED = (din0_SIGNED != 0) || (din1_SIGNED != 0);

  localparam logic signed [Q-1:0] L_ONE = {{(Q-1){1'b0}}, 1'b1};
  localparam logic signed [Q-1:0] L_RND = (ROUND != 0) ? ((L_ONE <<< SHIFT) >>> 1) : '0;
  localparam logic signed [Q-1:0] L_MAX = RES_SIGNED ? ((L_ONE <<< (dout_WIDTH-1)) - L_ONE)
                                                     : ((L_ONE <<< dout_WIDTH) - L_ONE);
  localparam logic signed [Q-1:0] L_MIN = RES_SIGNED ? -(L_ONE <<< (dout_WIDTH-1)) : '0;

  logic                  w_en;
  logic signed [din0_WIDTH:0] w_a;
  logic signed [din1_WIDTH:0] w_b;
  logic signed [P-1:0]   w_a_ext;
  logic signed [P-1:0]   w_b_ext;
  logic signed [P-1:0]   w_prod;
  logic signed [P-1:0]   w_src;
  logic                  w_src_vld;
  logic signed [Q-1:0]   w_ext;
  logic signed [Q-1:0]   w_rnd;
  logic signed [Q-1:0]   w_shf;
  logic [dout_WIDTH-1:0] w_res;
  logic                  w_clamp;

  logic [NUM_STAGE-1:0]  r_vld;
  logic [dout_WIDTH-1:0] r_dout;
  logic                  r_sat;
  logic [15:0]           r_cnt;

  assign w_en      = !r_vld[NUM_STAGE-1] || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_vld[NUM_STAGE-1];
  assign dout      = r_dout;
  assign sat_flag  = r_sat;
  assign sat_cnt   = r_cnt;

  // One extra bit per operand makes a single signed multiply exact for any signedness mix.
  assign w_a     = {(din0_SIGNED != 0) && din0[din0_WIDTH-1], din0};
  assign w_b     = {(din1_SIGNED != 0) && din1[din1_WIDTH-1], din1};
  assign w_a_ext = P'(w_a);
  assign w_b_ext = P'(w_b);
  assign w_prod  = w_a_ext * w_b_ext;

  generate
    if (NUM_STAGE == 1) begin : g_single
      assign w_src     = w_prod;
      assign w_src_vld = in_valid;
    end else begin : g_multi
      logic signed [P-1:0] r_prod [NUM_STAGE-1];

      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          for (int i = 0; i < NUM_STAGE-1; i++) r_prod[i] <= '0;
        end else if (w_en) begin
          if (in_valid) r_prod[0] <= w_prod;
          for (int i = 1; i < NUM_STAGE-1; i++) begin
            if (r_vld[i-1]) r_prod[i] <= r_prod[i-1];
          end
        end
      end

      assign w_src     = r_prod[NUM_STAGE-2];
      assign w_src_vld = r_vld[NUM_STAGE-2];
    end
  endgenerate

  assign w_ext = Q'(w_src);
  assign w_rnd = w_ext + L_RND;
  assign w_shf = w_rnd >>> SHIFT;

  always_comb begin
    w_res   = w_shf[dout_WIDTH-1:0];
    w_clamp = 1'b0;
    if (SAT != 0) begin
      if (w_shf > L_MAX) begin
        w_res   = L_MAX[dout_WIDTH-1:0];
        w_clamp = 1'b1;
      end else if (w_shf < L_MIN) begin
        w_res   = L_MIN[dout_WIDTH-1:0];
        w_clamp = 1'b1;
      end
    end
  end

  // Bubbles only move the valid bit; data registers load when their source is valid.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_vld  <= '0;
      r_dout <= '0;
      r_sat  <= 1'b0;
    end else if (w_en) begin
      r_vld[0] <= in_valid;
      for (int i = 1; i < NUM_STAGE; i++) r_vld[i] <= r_vld[i-1];
      if (w_src_vld) begin
        r_dout <= w_res;
        r_sat  <= w_clamp;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (r_vld[NUM_STAGE-1] && out_ready && r_sat && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_case_1_mul_pipe_rs.sv
// Directed bench for case_1_mul_pipe_rs at default parameters (14s x 12s -> 16, SHIFT=8, round, sat, 3 stages).
module tb_case_1_mul_pipe_rs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] din0;
  logic [11:0] din1;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] dout;
  logic        sat_flag;
  logic        cnt_clr;
  logic [15:0] sat_cnt;

  int checks = 0;
  int errors = 0;

  int bp_a   [5] = '{1, 2, 4, 3, 5};
  int bp_b   [5] = '{1, 4, 8, 256, 256};
  int bp_exp [5] = '{0, 0, 0, 3, 5};
  int nin, nout, stall_left;
  bit seen;

  case_1_mul_pipe_rs dut (
    .ap_clk    (clk),
    .ap_rst_n  (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din0      (din0),
    .din1      (din1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .sat_flag  (sat_flag),
    .cnt_clr   (cnt_clr),
    .sat_cnt   (sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    din0      = '0;
    din1      = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_dout", dout, 0);
    check("rst_sat_flag", sat_flag, 0);
    check("rst_sat_cnt", sat_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_in_ready", in_ready, 1);

    // single pair 1000 x -300
    in_valid = 1'b1; din0 = 14'd1000; din1 = 12'hED4;
    tick();
    in_valid = 1'b0;
    tick();
    check("lat_not_early", out_valid, 0);
    tick();
    check("single_valid", out_valid, 1);
    check("single_dout", dout, 16'hFB6C);
    check("single_sat", sat_flag, 0);
    tick();
    check("single_retired", out_valid, 0);

    // positive then negative saturation
    in_valid = 1'b1; din0 = 14'h1FFF; din1 = 12'h7FF;
    tick();
    din0 = 14'h2000; din1 = 12'h7FF;
    tick();
    in_valid = 1'b0;
    tick();
    check("satp_valid", out_valid, 1);
    check("satp_dout", dout, 16'h7FFF);
    check("satp_flag", sat_flag, 1);
    tick();
    check("satn_valid", out_valid, 1);
    check("satn_dout", dout, 16'h8000);
    check("satn_flag", sat_flag, 1);
    tick();
    check("sat_drained", out_valid, 0);
    check("sat_cnt_2", sat_cnt, 2);

    // backpressure: 4-cycle stall after first result
    nin = 0; nout = 0; stall_left = 0; seen = 1'b0;
    for (int cyc = 0; cyc < 40 && nout < 5; cyc++) begin
      if (out_valid && !seen) begin
        seen = 1'b1;
        stall_left = 4;
      end
      out_ready = (stall_left == 0);
      in_valid  = (nin < 5);
      din0      = (nin < 5) ? 14'(bp_a[nin]) : '0;
      din1      = (nin < 5) ? 12'(bp_b[nin]) : '0;
      #1;
      if (stall_left > 0) begin
        check("bp_in_ready_low", in_ready, 0);
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_dout", dout, 32'(bp_exp[nout]));
        stall_left--;
      end
      if (out_valid && out_ready) begin
        check("bp_order_dout", dout, 32'(bp_exp[nout]));
        check("bp_order_sat", sat_flag, 0);
        nout++;
      end
      if (in_valid && in_ready) nin++;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_result_count", nout, 5);
    check("bp_stall_seen", 32'(seen), 1);
    tick();
    check("bp_drained", out_valid, 0);

    // reset with three pairs in flight
    out_ready = 1'b0;
    in_valid = 1'b1; din0 = 14'd100; din1 = 12'd100;
    tick();
    din0 = 14'd200;
    tick();
    din0 = 14'd300;
    tick();
    in_valid = 1'b0;
    check("midrst_full", out_valid, 1);
    check("midrst_in_ready", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid_drop", out_valid, 0);
    check("midrst_in_ready_rst", in_ready, 1);
    check("midrst_dout_zero", dout, 0);
    check("midrst_cnt_zero", sat_cnt, 0);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("midrst_no_output", out_valid, 0);
    end

    // counter saturates at 0xFFFF under a long clamped stream
    in_valid = 1'b1; din0 = 14'h1FFF; din1 = 12'h7FF;
    repeat (65540) @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) tick();
    check("cnt_stream_drained", out_valid, 0);
    check("cnt_hold_ffff", sat_cnt, 16'hFFFF);

    // clear wins over a simultaneous clamped handshake
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("clr_out_valid", out_valid, 1);
    check("clr_out_sat", sat_flag, 1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_priority", sat_cnt, 0);

    // counting resumes after clear
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("resume_valid", out_valid, 1);
    tick();
    check("resume_cnt_1", sat_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
